// File: rtl/fp_writeback_arbiter.sv
// rtl/fp_writeback_arbiter.sv - two-source FP result write-back arbiter with RAW pending lookup
module fp_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fast_valid,
  output logic        fast_ready,
  input  logic [4:0]  fast_reg,
  input  logic [31:0] fast_data,
  input  logic        slow_valid,
  output logic        slow_ready,
  input  logic [4:0]  slow_reg,
  input  logic [31:0] slow_data,
  output logic        write_enable,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  input  logic [4:0]  query_reg1,
  input  logic [4:0]  query_reg2,
  output logic        pending1,
  output logic        pending2,
  output logic        idle
);

  localparam int CW = PTR_W + 1;
  localparam logic [PTR_W:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    GRANT_FAST = 1'b0,
    GRANT_SLOW = 1'b1
  } grant_t;

  logic [4:0]       fast_reg_mem  [DEPTH];
  logic [31:0]      fast_data_mem [DEPTH];
  logic [4:0]       slow_reg_mem  [DEPTH];
  logic [31:0]      slow_data_mem [DEPTH];

  logic [PTR_W-1:0] fast_wr_ptr;
  logic [PTR_W-1:0] fast_rd_ptr;
  logic [PTR_W:0]   fast_count;
  logic [PTR_W-1:0] slow_wr_ptr;
  logic [PTR_W-1:0] slow_rd_ptr;
  logic [PTR_W:0]   slow_count;

  grant_t           last_grant;
  grant_t           last_grant_next;

  logic             fast_push;
  logic             slow_push;
  logic             fast_nonempty;
  logic             slow_nonempty;
  logic             grant_fast;
  logic             grant_slow;

  logic [DEPTH-1:0] fast_live;
  logic [DEPTH-1:0] slow_live;

  // A slot holds a buffered result when its distance from rd_ptr (mod DEPTH) is below count.
  function automatic logic slot_live(input logic [PTR_W-1:0] slot,
                                     input logic [PTR_W-1:0] rd_ptr,
                                     input logic [PTR_W:0]   count);
    logic [PTR_W-1:0] offset;
    offset = slot - rd_ptr;
    return ({1'b0, offset} < count);
  endfunction

  // Ready comes only from registered counts, so a full FIFO never accepts on the edge it pops.
  always_comb begin
    fast_ready    = reset && (fast_count != FULL_COUNT);
    slow_ready    = reset && (slow_count != FULL_COUNT);
    fast_push     = fast_valid && fast_ready;
    slow_push     = slow_valid && slow_ready;
    fast_nonempty = (fast_count != '0);
    slow_nonempty = (slow_count != '0);
  end

  // Round-robin on contention; a lone non-empty source is always granted.
  always_comb begin
    grant_fast      = 1'b0;
    grant_slow      = 1'b0;
    last_grant_next = last_grant;
    if (fast_nonempty && slow_nonempty) begin
      if (last_grant == GRANT_SLOW) begin
        grant_fast      = 1'b1;
        last_grant_next = GRANT_FAST;
      end else begin
        grant_slow      = 1'b1;
        last_grant_next = GRANT_SLOW;
      end
    end else if (fast_nonempty) begin
      grant_fast = 1'b1;
    end else if (slow_nonempty) begin
      grant_slow = 1'b1;
    end
  end

  // Fast FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fast_wr_ptr <= '0;
      fast_rd_ptr <= '0;
      fast_count  <= '0;
    end else begin
      if (fast_push) fast_wr_ptr <= fast_wr_ptr + PTR_W'(1);
      if (grant_fast) fast_rd_ptr <= fast_rd_ptr + PTR_W'(1);
      case ({fast_push, grant_fast})
        2'b10:   fast_count <= fast_count + CW'(1);
        2'b01:   fast_count <= fast_count - CW'(1);
        default: fast_count <= fast_count;
      endcase
    end
  end

  // Slow FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slow_wr_ptr <= '0;
      slow_rd_ptr <= '0;
      slow_count  <= '0;
    end else begin
      if (slow_push) slow_wr_ptr <= slow_wr_ptr + PTR_W'(1);
      if (grant_slow) slow_rd_ptr <= slow_rd_ptr + PTR_W'(1);
      case ({slow_push, grant_slow})
        2'b10:   slow_count <= slow_count + CW'(1);
        2'b01:   slow_count <= slow_count - CW'(1);
        default: slow_count <= slow_count;
      endcase
    end
  end

  // FIFO storage needs no reset: only slots inside count are ever read or matched.
  always_ff @(posedge clk) begin
    if (fast_push) begin
      fast_reg_mem[fast_wr_ptr]  <= fast_reg;
      fast_data_mem[fast_wr_ptr] <= fast_data;
    end
    if (slow_push) begin
      slow_reg_mem[slow_wr_ptr]  <= slow_reg;
      slow_data_mem[slow_wr_ptr] <= slow_data;
    end
  end

  // Registered write port and round-robin history; fast wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_reg    <= '0;
      write_data   <= '0;
      last_grant   <= GRANT_SLOW;
    end else begin
      last_grant <= last_grant_next;
      if (grant_fast) begin
        write_enable <= 1'b1;
        write_reg    <= fast_reg_mem[fast_rd_ptr];
        write_data   <= fast_data_mem[fast_rd_ptr];
      end else if (grant_slow) begin
        write_enable <= 1'b1;
        write_reg    <= slow_reg_mem[slow_rd_ptr];
        write_data   <= slow_data_mem[slow_rd_ptr];
      end else begin
        write_enable <= 1'b0;
      end
    end
  end

  // Mark which storage slots currently hold uncommitted results.
  always_comb begin
    fast_live = '0;
    slow_live = '0;
    for (int j = 0; j < DEPTH; j++) begin
      fast_live[j] = slot_live(PTR_W'(j), fast_rd_ptr, fast_count);
      slow_live[j] = slot_live(PTR_W'(j), slow_rd_ptr, slow_count);
    end
  end

  // RAW lookup against both FIFOs and the write currently on the register-file port.
  always_comb begin
    pending1 = 1'b0;
    pending2 = 1'b0;
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (fast_live[j] && (fast_reg_mem[j] == query_reg1)) pending1 = 1'b1;
        if (slow_live[j] && (slow_reg_mem[j] == query_reg1)) pending1 = 1'b1;
        if (fast_live[j] && (fast_reg_mem[j] == query_reg2)) pending2 = 1'b1;
        if (slow_live[j] && (slow_reg_mem[j] == query_reg2)) pending2 = 1'b1;
      end
      if (write_enable && (write_reg == query_reg1)) pending1 = 1'b1;
      if (write_enable && (write_reg == query_reg2)) pending2 = 1'b1;
    end
  end

  // Idle is forced while reset is held, since the registered state is about to be cleared.
  always_comb begin
    idle = !reset || ((fast_count == '0) && (slow_count == '0) && !write_enable);
  end

endmodule
